// File: rtl/tc_pl_cap_gain_lmh_srx_if.sv
// FDA0 gain-link SPI pins. The master drives clock, select and data;
// the receiver only observes them.
interface tc_pl_cap_gain_lmh_srx_if;
  logic FDA0_SCK;
  logic FDA0_CSN;
  logic FDA0_SDI;

  modport master (output FDA0_SCK, output FDA0_CSN, output FDA0_SDI);
  modport slave  (input  FDA0_SCK, input  FDA0_CSN, input  FDA0_SDI);
endinterface

// File: rtl/tc_pl_cap_gain_lmh_srx.sv
// Oversampling SPI slave (mode 0, MSB first) for the FDA0 gain link: captures one
// frame per CSN low window, rejects malformed frames and decodes the gain code.
module tc_pl_cap_gain_lmh_srx #(
  parameter int CAP0_13 = 6,
  parameter int SPI0_0  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  tc_pl_cap_gain_lmh_srx_if.slave  fda,
  output logic                     srx_busy,
  output logic                     srx_valid,
  output logic [SPI0_0-1:0]        srx_data,
  output logic                     srx_err,
  output logic [CAP0_13-1:0]       gset_lmh,
  output logic [7:0]               frame_cnt
);

  localparam int CW = $clog2(SPI0_0 + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(SPI0_0);
  localparam logic [CW-1:0] CNT_OVF  = CW'(SPI0_0 + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic sck_m, sck_s, sck_d;
  logic csn_m, csn_s, csn_d;
  logic sdi_m, sdi_s;
  logic sck_rise, csn_fall, csn_rise;

  state_t            state, state_nxt;
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [SPI0_0-1:0] shreg, shreg_nxt;
  logic              pend_ok, pend_ok_nxt;
  logic              pend_err, pend_err_nxt;

  // CSN chain resets high so that leaving reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_m <= 1'b0;
      sck_s <= 1'b0;
      sck_d <= 1'b0;
      csn_m <= 1'b1;
      csn_s <= 1'b1;
      csn_d <= 1'b1;
      sdi_m <= 1'b0;
      sdi_s <= 1'b0;
    end else begin
      sck_m <= fda.FDA0_SCK;
      sck_s <= sck_m;
      sck_d <= sck_s;
      csn_m <= fda.FDA0_CSN;
      csn_s <= csn_m;
      csn_d <= csn_s;
      sdi_m <= fda.FDA0_SDI;
      sdi_s <= sdi_m;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign csn_fall = ~csn_s & csn_d;
  assign csn_rise = csn_s & ~csn_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      pend_ok  <= 1'b0;
      pend_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      pend_ok  <= pend_ok_nxt;
      pend_err <= pend_err_nxt;
    end
  end

  // A CSN rise takes priority over a coincident SCK rise, so that bit is dropped.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    pend_ok_nxt  = 1'b0;
    pend_err_nxt = 1'b0;
    srx_busy     = 1'b0;
    case (state)
      IDLE: begin
        if (csn_fall) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
          shreg_nxt   = '0;
          srx_busy    = 1'b1;
        end
      end
      SHIFT: begin
        if (csn_rise) begin
          state_nxt = CHECK;
        end else begin
          srx_busy = 1'b1;
          if (sck_rise) begin
            shreg_nxt = {shreg[SPI0_0-2:0], sdi_s};
            if (bit_cnt != CNT_OVF) begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (bit_cnt == '0) begin
          pend_ok_nxt = 1'b0;
        end else if (bit_cnt != CNT_FULL) begin
          pend_err_nxt = 1'b1;
        end else if (shreg[SPI0_0-1:CAP0_13] != '0) begin
          pend_err_nxt = 1'b1;
        end else begin
          pend_ok_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Verdict is staged one cycle so results land four clocks after the CSN rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srx_valid <= 1'b0;
      srx_err   <= 1'b0;
      srx_data  <= '0;
      gset_lmh  <= '0;
      frame_cnt <= '0;
    end else begin
      srx_valid <= pend_ok;
      srx_err   <= pend_err;
      if (pend_ok) begin
        srx_data  <= shreg;
        gset_lmh  <= shreg[CAP0_13-1:0];
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
